// File: rtl/frame_capture_buffer_pkg.sv
// Shared definitions for the frame capture buffer: FSM encodings, byte width
// and the default FIFO depth.
package frame_capture_buffer_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEFAULT_DEPTH = 16;

  // FSM state encodings (kept as plain constants for legacy tooling)
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_CAPTURE = 2'b01;
  localparam logic [1:0] ST_CLOSE   = 2'b10;

endpackage

// File: rtl/frame_capture_buffer_sync_byte_fifo.sv
// Synchronous byte FIFO: storage, wrapping pointers with an extra lap bit,
// EMPTY/FULL derived from the pointers, and a registered read port.
// Handshake: a write happens when wr_en=1 and full=0; a pop happens when
// rd_en=1 and empty=0, with rd_data/rd_valid presented on the next cycle.
module sync_byte_fifo
  import frame_capture_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full
);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  // Occupancy flags come straight from the registered pointers
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A read never makes room for a same-cycle write when full
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // Storage array; contents are don't-care until written
  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointer advance and registered read port
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/frame_capture_buffer.sv
// Frame capture buffer: captures the bytes of each WREN window into a FIFO
// and closes the window as a frame with length and XOR checksum.
// Handshake: each WREN-high cycle offers one byte; it is accepted only in
// IDLE/CAPTURE while the FIFO is not full, otherwise it is dropped and
// OVERFLOW is set. Reads use RD_EN with one cycle of latency to RD_VALID.
module frame_capture_buffer
  import frame_capture_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  DBUS,
  input  logic        WREN,
  input  logic        RD_EN,
  input  logic        CLR_OVF,
  output logic [7:0]  RD_DATA,
  output logic        RD_VALID,
  output logic        EMPTY,
  output logic        FULL,
  output logic        FRAME_DONE,
  output logic [7:0]  FRAME_LEN,
  output logic [7:0]  CHKSUM,
  output logic        OVERFLOW,
  output logic [1:0]  DBG_STATE
);

  logic [1:0] state;
  logic [7:0] run_len;
  logic [7:0] run_xor;
  logic       in_window;
  logic       accept;
  logic       drop;

  assign DBG_STATE = state;

  // Bytes are only taken while the window is open; CLOSE always drops
  assign in_window = (state == ST_IDLE) || (state == ST_CAPTURE);
  assign accept    = WREN && in_window && !FULL;
  assign drop      = WREN && !accept;

  sync_byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .wr_en    (accept),
    .wr_data  (DBUS),
    .rd_en    (RD_EN),
    .rd_data  (RD_DATA),
    .rd_valid (RD_VALID),
    .empty    (EMPTY),
    .full     (FULL)
  );

  // Frame FSM with running length/checksum; results latch when the window ends
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      run_len    <= '0;
      run_xor    <= '0;
      FRAME_DONE <= 1'b0;
      FRAME_LEN  <= '0;
      CHKSUM     <= '0;
    end else begin
      FRAME_DONE <= 1'b0;
      if (accept) begin
        if (run_len != 8'hFF) run_len <= run_len + 8'd1;
        run_xor <= run_xor ^ DBUS;
      end
      case (state)
        ST_IDLE: begin
          if (WREN) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (!WREN) begin
            // FRAME_DONE is high for exactly the CLOSE cycle
            state      <= ST_CLOSE;
            FRAME_DONE <= 1'b1;
            FRAME_LEN  <= run_len;
            CHKSUM     <= run_xor;
            run_len    <= '0;
            run_xor    <= '0;
          end
        end
        ST_CLOSE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky overflow; a drop in the clearing cycle keeps the flag set
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OVERFLOW <= 1'b0;
    end else if (drop) begin
      OVERFLOW <= 1'b1;
    end else if (CLR_OVF) begin
      OVERFLOW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_capture_buffer.sv
// Directed self-checking bench for frame_capture_buffer.
module tb_frame_capture_buffer;

  logic       CLK;
  logic       RST_N;
  logic [7:0] DBUS;
  logic       WREN;
  logic       RD_EN;
  logic       CLR_OVF;
  logic [7:0] RD_DATA;
  logic       RD_VALID;
  logic       EMPTY;
  logic       FULL;
  logic       FRAME_DONE;
  logic [7:0] FRAME_LEN;
  logic [7:0] CHKSUM;
  logic       OVERFLOW;
  logic [1:0] DBG_STATE;

  int checks = 0;
  int errors = 0;

  frame_capture_buffer #(.DEPTH(16), .AW(4)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .DBUS       (DBUS),
    .WREN       (WREN),
    .RD_EN      (RD_EN),
    .CLR_OVF    (CLR_OVF),
    .RD_DATA    (RD_DATA),
    .RD_VALID   (RD_VALID),
    .EMPTY      (EMPTY),
    .FULL       (FULL),
    .FRAME_DONE (FRAME_DONE),
    .FRAME_LEN  (FRAME_LEN),
    .CHKSUM     (CHKSUM),
    .OVERFLOW   (OVERFLOW),
    .DBG_STATE  (DBG_STATE)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one edge; outputs are sampled 1ns after it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rd_data"},  RD_DATA,    0);
    chk({tag, "_rd_valid"}, RD_VALID,   0);
    chk({tag, "_empty"},    EMPTY,      1);
    chk({tag, "_full"},     FULL,       0);
    chk({tag, "_done"},     FRAME_DONE, 0);
    chk({tag, "_len"},      FRAME_LEN,  0);
    chk({tag, "_chk"},      CHKSUM,     0);
    chk({tag, "_ovf"},      OVERFLOW,   0);
  endtask

  task automatic write_byte(input logic [7:0] b);
    WREN = 1'b1;
    DBUS = b;
    tick();
  endtask

  task automatic read_expect(input string tag, input logic [7:0] exp);
    RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0;
    chk({tag, "_valid"}, RD_VALID, 1);
    chk({tag, "_data"},  RD_DATA,  exp);
  endtask

  logic [7:0] exp_rd [8];

  initial begin
    RST_N = 1'b0; DBUS = '0; WREN = 1'b0; RD_EN = 1'b0; CLR_OVF = 1'b0;
    tick(); tick();
    chk_reset_values("reset");
    chk("reset_state", DBG_STATE, 2'b00);
    RST_N = 1'b1;
    tick();

    // Single frame 11,22,33,44
    write_byte(8'h11);
    chk("t1_empty_after_first", EMPTY, 0);
    chk("t1_state_capture", DBG_STATE, 2'b01);
    write_byte(8'h22);
    write_byte(8'h33);
    write_byte(8'h44);
    WREN = 1'b0;
    tick();
    chk("t1_done", FRAME_DONE, 1);
    chk("t1_len",  FRAME_LEN,  8'd4);
    chk("t1_chk",  CHKSUM,     8'h44);
    chk("t1_state_close", DBG_STATE, 2'b10);
    tick();
    chk("t1_done_pulse", FRAME_DONE, 0);
    chk("t1_len_hold",   FRAME_LEN,  8'd4);
    read_expect("t1_rd0", 8'h11);
    read_expect("t1_rd1", 8'h22);
    read_expect("t1_rd2", 8'h33);
    read_expect("t1_rd3", 8'h44);
    chk("t1_empty_end", EMPTY, 1);

    // Overflow: 18 bytes 00..11 into a 16-deep FIFO
    for (int i = 0; i < 18; i++) begin
      write_byte(i[7:0]);
      if (i == 15) chk("t2_full_at_16", FULL, 1);
      if (i == 15) chk("t2_no_ovf_yet", OVERFLOW, 0);
    end
    WREN = 1'b0;
    chk("t2_full", FULL, 1);
    chk("t2_ovf",  OVERFLOW, 1);
    tick();
    chk("t2_done", FRAME_DONE, 1);
    chk("t2_len",  FRAME_LEN,  8'd16);
    chk("t2_chk",  CHKSUM,     8'h00);
    tick();
    for (int i = 0; i < 16; i++) begin
      read_expect($sformatf("t2_rd%0d", i), i[7:0]);
      if (i == 0) chk("t2_not_full", FULL, 0);
    end
    chk("t2_empty", EMPTY, 1);

    // Empty read and overflow clear
    RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0;
    chk("t3_empty_rd_valid", RD_VALID, 0);
    chk("t3_empty_rd_data",  RD_DATA,  8'h0F);
    chk("t3_ovf_sticky",     OVERFLOW, 1);
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    chk("t3_ovf_clr", OVERFLOW, 0);

    // Simultaneous read/write at 8 bytes, crossing address 15 -> 0
    for (int i = 0; i < 8; i++) write_byte(8'hA0 + i[7:0]);
    for (int i = 0; i < 5; i++) begin
      WREN = 1'b1; DBUS = 8'hB0 + i[7:0]; RD_EN = 1'b1;
      tick();
      chk($sformatf("t4_rw_data%0d", i), RD_DATA, 8'hA0 + i[7:0]);
      chk($sformatf("t4_rw_valid%0d", i), RD_VALID, 1);
    end
    WREN = 1'b0; RD_EN = 1'b0;
    tick();
    chk("t4_done", FRAME_DONE, 1);
    chk("t4_len",  FRAME_LEN,  8'd13);
    chk("t4_chk",  CHKSUM,     8'hB4);
    tick();
    exp_rd = '{8'hA5, 8'hA6, 8'hA7, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    for (int i = 0; i < 8; i++) begin
      read_expect($sformatf("t4_drain%0d", i), exp_rd[i]);
      if (i == 6) chk("t4_not_empty_at_7", EMPTY, 0);
    end
    chk("t4_empty", EMPTY, 1);

    // Reset mid-frame after 3 bytes
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    WREN = 1'b0;
    RST_N = 1'b0;
    #1;
    chk_reset_values("t5_async");
    chk("t5_state", DBG_STATE, 2'b00);
    tick();
    RST_N = 1'b1;
    tick();
    chk("t5_no_done", FRAME_DONE, 0);
    tick();
    chk("t5_no_done2", FRAME_DONE, 0);
    chk("t5_empty", EMPTY, 1);
    write_byte(8'hAB);
    write_byte(8'hCD);
    WREN = 1'b0;
    tick();
    chk("t5_done", FRAME_DONE, 1);
    chk("t5_len",  FRAME_LEN,  8'd2);
    chk("t5_chk",  CHKSUM,     8'h66);
    tick();

    // Back-to-back frames with a one-cycle gap; the CLOSE-cycle byte is dropped
    write_byte(8'h10);
    write_byte(8'h20);
    write_byte(8'h40);
    WREN = 1'b0;
    tick();
    chk("t6_done_a", FRAME_DONE, 1);
    chk("t6_len_a",  FRAME_LEN,  8'd3);
    chk("t6_chk_a",  CHKSUM,     8'h70);
    chk("t6_ovf_before", OVERFLOW, 0);
    CLR_OVF = 1'b1;
    write_byte(8'hEE);
    CLR_OVF = 1'b0;
    chk("t6_ovf_set_wins", OVERFLOW, 1);
    chk("t6_done_a_pulse", FRAME_DONE, 0);
    write_byte(8'h05);
    write_byte(8'h06);
    WREN = 1'b0;
    tick();
    chk("t6_done_b", FRAME_DONE, 1);
    chk("t6_len_b",  FRAME_LEN,  8'd2);
    chk("t6_chk_b",  CHKSUM,     8'h03);
    tick();
    exp_rd = '{8'hAB, 8'hCD, 8'h10, 8'h20, 8'h40, 8'h05, 8'h06, 8'h00};
    for (int i = 0; i < 7; i++) read_expect($sformatf("t6_rd%0d", i), exp_rd[i]);
    chk("t6_empty", EMPTY, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
